// File: rtl/decode.sv
// Decode stage: 32x32 register file with write-before-read bypass, MIPS-subset
// decoder, load-use hazard detection, and a registered bundle for execute.
package decode_pkg;
  localparam int unsigned XLEN   = 32;
  localparam int unsigned REG_AW = 5;
  localparam int unsigned NREG   = 32;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ADDIU = 6'h09;
  localparam logic [5:0] OP_SLTI  = 6'h0A;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_XORI  = 6'h0E;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] F_SLL  = 6'h00;
  localparam logic [5:0] F_SRL  = 6'h02;
  localparam logic [5:0] F_SRA  = 6'h03;
  localparam logic [5:0] F_ADD  = 6'h20;
  localparam logic [5:0] F_ADDU = 6'h21;
  localparam logic [5:0] F_SUB  = 6'h22;
  localparam logic [5:0] F_SUBU = 6'h23;
  localparam logic [5:0] F_AND  = 6'h24;
  localparam logic [5:0] F_OR   = 6'h25;
  localparam logic [5:0] F_XOR  = 6'h26;
  localparam logic [5:0] F_NOR  = 6'h27;
  localparam logic [5:0] F_SLT  = 6'h2A;
  localparam logic [5:0] F_SLTU = 6'h2B;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'd0,  ALU_SUB = 4'd1, ALU_AND = 4'd2, ALU_OR  = 4'd3,
    ALU_XOR  = 4'd4,  ALU_NOR = 4'd5, ALU_SLT = 4'd6, ALU_SLTU = 4'd7,
    ALU_SLL  = 4'd8,  ALU_SRL = 4'd9, ALU_SRA = 4'd10, ALU_LUI = 4'd11
  } alu_op_e;

  typedef enum logic [1:0] {
    BR_NONE = 2'd0, BR_BEQ = 2'd1, BR_BNE = 2'd2, BR_J = 2'd3
  } branch_e;

  typedef struct packed {
    logic              valid;
    logic [XLEN-1:0]   pc;
    logic [XLEN-1:0]   rs_data;
    logic [XLEN-1:0]   rt_data;
    logic [XLEN-1:0]   imm;
    logic [REG_AW-1:0] shamt;
    logic [REG_AW-1:0] dest;
    alu_op_e           alu_op;
    logic              alu_src;
    logic              mem_rd;
    logic              mem_wr;
    logic              reg_wr;
    branch_e           branch;
    logic              illegal;
  } bundle_t;
endpackage

module decode
  import decode_pkg::*;
(
  input  logic              clk_in,
  input  logic              rst_n_in,
  input  logic [XLEN-1:0]   insn_in,
  input  logic [XLEN-1:0]   pc_in,
  input  logic              valid_in,
  input  logic              stall_in,
  input  logic              wb_en_in,
  input  logic [REG_AW-1:0] wb_addr_in,
  input  logic [XLEN-1:0]   wb_data_in,
  output logic              stall_out,
  output logic              valid_out,
  output logic [XLEN-1:0]   pc_out,
  output logic [XLEN-1:0]   rs_data_out,
  output logic [XLEN-1:0]   rt_data_out,
  output logic [XLEN-1:0]   imm_out,
  output logic [REG_AW-1:0] shamt_out,
  output logic [REG_AW-1:0] dest_out,
  output logic [3:0]        alu_op_out,
  output logic              alu_src_out,
  output logic              mem_rd_out,
  output logic              mem_wr_out,
  output logic              reg_wr_out,
  output logic [1:0]        branch_out,
  output logic              illegal_out
);

  logic [XLEN-1:0]   regs_q [NREG];
  logic [XLEN-1:0]   regs_d [NREG];
  bundle_t           bundle_q, bundle_d, dec;
  logic [5:0]        opcode, funct;
  logic [REG_AW-1:0] rs, rt, rd;
  logic [XLEN-1:0]   rs_val, rt_val, imm_sext, imm_zext;
  logic              reads_rt, hazard;

  assign opcode   = insn_in[31:26];
  assign funct    = insn_in[5:0];
  assign rs       = insn_in[25:21];
  assign rt       = insn_in[20:16];
  assign rd       = insn_in[15:11];
  assign imm_sext = {{16{insn_in[15]}}, insn_in[15:0]};
  assign imm_zext = {16'h0000, insn_in[15:0]};

  // Register file write; $0 is never written
  always_comb begin
    regs_d = regs_q;
    if (wb_en_in && (wb_addr_in != '0)) regs_d[wb_addr_in] = wb_data_in;
  end

  always_ff @(posedge clk_in) begin
    if (!rst_n_in) regs_q <= '{default: '0};
    else           regs_q <= regs_d;
  end

  // Operand reads with same-cycle writeback bypass
  always_comb begin
    rs_val = regs_q[rs];
    rt_val = regs_q[rt];
    if (rs == '0)                                rs_val = '0;
    else if (wb_en_in && (wb_addr_in == rs))     rs_val = wb_data_in;
    if (rt == '0)                                rt_val = '0;
    else if (wb_en_in && (wb_addr_in == rt))     rt_val = wb_data_in;
  end

  // Instruction decode into a candidate bundle
  always_comb begin
    dec         = '0;
    reads_rt    = 1'b0;
    dec.valid   = 1'b1;
    dec.pc      = pc_in;
    dec.rs_data = rs_val;
    dec.rt_data = rt_val;
    dec.shamt   = insn_in[10:6];
    case (opcode)
      OP_RTYPE: begin
        reads_rt   = 1'b1;
        dec.dest   = rd;
        dec.reg_wr = 1'b1;
        case (funct)
          F_ADD, F_ADDU: dec.alu_op = ALU_ADD;
          F_SUB, F_SUBU: dec.alu_op = ALU_SUB;
          F_AND:         dec.alu_op = ALU_AND;
          F_OR:          dec.alu_op = ALU_OR;
          F_XOR:         dec.alu_op = ALU_XOR;
          F_NOR:         dec.alu_op = ALU_NOR;
          F_SLT:         dec.alu_op = ALU_SLT;
          F_SLTU:        dec.alu_op = ALU_SLTU;
          F_SLL:         dec.alu_op = ALU_SLL;
          F_SRL:         dec.alu_op = ALU_SRL;
          F_SRA:         dec.alu_op = ALU_SRA;
          default:       dec.illegal = 1'b1;
        endcase
      end
      OP_ADDI, OP_ADDIU, OP_SLTI: begin
        dec.alu_op  = (opcode == OP_SLTI) ? ALU_SLT : ALU_ADD;
        dec.alu_src = 1'b1;
        dec.reg_wr  = 1'b1;
        dec.dest    = rt;
        dec.imm     = imm_sext;
      end
      OP_ANDI, OP_ORI, OP_XORI: begin
        dec.alu_op  = (opcode == OP_ANDI) ? ALU_AND :
                      (opcode == OP_ORI)  ? ALU_OR  : ALU_XOR;
        dec.alu_src = 1'b1;
        dec.reg_wr  = 1'b1;
        dec.dest    = rt;
        dec.imm     = imm_zext;
      end
      OP_LUI: begin
        dec.alu_op  = ALU_LUI;
        dec.alu_src = 1'b1;
        dec.reg_wr  = 1'b1;
        dec.dest    = rt;
        dec.imm     = {insn_in[15:0], 16'h0000};
      end
      OP_LW: begin
        dec.alu_src = 1'b1;
        dec.mem_rd  = 1'b1;
        dec.reg_wr  = 1'b1;
        dec.dest    = rt;
        dec.imm     = imm_sext;
      end
      OP_SW: begin
        reads_rt    = 1'b1;
        dec.alu_src = 1'b1;
        dec.mem_wr  = 1'b1;
        dec.imm     = imm_sext;
      end
      OP_BEQ, OP_BNE: begin
        reads_rt   = 1'b1;
        dec.alu_op = ALU_SUB;
        dec.branch = (opcode == OP_BEQ) ? BR_BEQ : BR_BNE;
        dec.imm    = imm_sext;
      end
      OP_J: begin
        dec.branch = BR_J;
        dec.imm    = {pc_in[31:28], insn_in[25:0], 2'b00};
      end
      default: dec.illegal = 1'b1;
    endcase
    // Illegal encodings carry no control or immediate, only the flag
    if (dec.illegal) begin
      dec.imm     = '0;
      dec.dest    = '0;
      dec.alu_op  = ALU_ADD;
      dec.alu_src = 1'b0;
      dec.mem_rd  = 1'b0;
      dec.mem_wr  = 1'b0;
      dec.reg_wr  = 1'b0;
      dec.branch  = BR_NONE;
    end
  end

  // Load in the registered bundle feeding a source of the current instruction
  assign hazard = bundle_q.valid && bundle_q.mem_rd && (bundle_q.dest != '0) &&
                  ((bundle_q.dest == rs) || (reads_rt && (bundle_q.dest == rt)));

  assign stall_out = stall_in | (rst_n_in & hazard);

  // Hold under downstream stall, bubble on hazard or empty slot
  always_comb begin
    bundle_d = bundle_q;
    if (!stall_in) begin
      if (hazard || !valid_in) bundle_d = '0;
      else                     bundle_d = dec;
    end
  end

  always_ff @(posedge clk_in) begin
    if (!rst_n_in) bundle_q <= '0;
    else           bundle_q <= bundle_d;
  end

  assign valid_out   = bundle_q.valid;
  assign pc_out      = bundle_q.pc;
  assign rs_data_out = bundle_q.rs_data;
  assign rt_data_out = bundle_q.rt_data;
  assign imm_out     = bundle_q.imm;
  assign shamt_out   = bundle_q.shamt;
  assign dest_out    = bundle_q.dest;
  assign alu_op_out  = bundle_q.alu_op;
  assign alu_src_out = bundle_q.alu_src;
  assign mem_rd_out  = bundle_q.mem_rd;
  assign mem_wr_out  = bundle_q.mem_wr;
  assign reg_wr_out  = bundle_q.reg_wr;
  assign branch_out  = bundle_q.branch;
  assign illegal_out = bundle_q.illegal;

endmodule

// File: tb/tb_decode.sv
// Self-checking bench for decode: directed vector table, hand-written multi-cycle
// sequences, and randomized traffic against a table-driven reference model.
module tb_decode;
  localparam int unsigned CW = 150;

  typedef struct packed {
    logic        valid;
    logic [31:0] pc, rs, rt, imm;
    logic [4:0]  shamt, dest;
    logic [3:0]  alu;
    logic        src, mrd, mwr, rwr;
    logic [1:0]  br;
    logic        ill;
  } bun_t;

  typedef struct {
    logic [31:0] insn, pc;
    logic [3:0]  alu;
    logic        src;
    logic [31:0] imm;
    logic [4:0]  dest;
    logic        rwr, mrd, mwr;
    logic [1:0]  br;
    logic        ill;
  } vec_t;

  logic        clk_in = 1'b0;
  logic        rst_n_in = 1'b0, valid_in = 1'b0, stall_in = 1'b0, wb_en_in = 1'b0;
  logic [31:0] insn_in = '0, pc_in = '0, wb_data_in = '0;
  logic [4:0]  wb_addr_in = '0;
  logic        stall_out, valid_out, alu_src_out, mem_rd_out, mem_wr_out, reg_wr_out, illegal_out;
  logic [31:0] pc_out, rs_data_out, rt_data_out, imm_out;
  logic [4:0]  shamt_out, dest_out;
  logic [3:0]  alu_op_out;
  logic [1:0]  branch_out;

  decode dut (
    .clk_in(clk_in), .rst_n_in(rst_n_in), .insn_in(insn_in), .pc_in(pc_in),
    .valid_in(valid_in), .stall_in(stall_in), .wb_en_in(wb_en_in),
    .wb_addr_in(wb_addr_in), .wb_data_in(wb_data_in), .stall_out(stall_out),
    .valid_out(valid_out), .pc_out(pc_out), .rs_data_out(rs_data_out),
    .rt_data_out(rt_data_out), .imm_out(imm_out), .shamt_out(shamt_out),
    .dest_out(dest_out), .alu_op_out(alu_op_out), .alu_src_out(alu_src_out),
    .mem_rd_out(mem_rd_out), .mem_wr_out(mem_wr_out), .reg_wr_out(reg_wr_out),
    .branch_out(branch_out), .illegal_out(illegal_out)
  );

  always #5 clk_in = ~clk_in;

  bun_t got;
  always_comb got = {valid_out, pc_out, rs_data_out, rt_data_out, imm_out, shamt_out,
                     dest_out, alu_op_out, alu_src_out, mem_rd_out, mem_wr_out,
                     reg_wr_out, branch_out, illegal_out};

  int          n_checks = 0, n_fail = 0;
  bun_t        mb;
  logic [31:0] mregs [32];
  logic [3:0]  r_tab [logic [5:0]];
  logic [3:0]  i_tab [logic [5:0]];
  logic        last_stall;
  vec_t        tab [18];

  task automatic chk(input string name, input logic [CW-1:0] act, input logic [CW-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] rd_reg(input logic [4:0] a, input logic we,
                                         input logic [4:0] wa, input logic [31:0] wd);
    if (a == 5'd0) return 32'd0;
    if (we && wa == a) return wd;
    return mregs[a];
  endfunction

  function automatic logic reads_rt(input logic [31:0] ins);
    logic [5:0] op;
    op = ins[31:26];
    return (op == 6'h00) || (op == 6'h2B) || (op == 6'h04) || (op == 6'h05);
  endfunction

  // Reference decode: opcode/funct lookup tables plus per-class field rules
  function automatic bun_t ref_decode(input logic [31:0] ins, input logic [31:0] pc,
                                      input logic [31:0] rsv, input logic [31:0] rtv);
    bun_t b;
    logic [5:0] op, fn;
    logic [31:0] sx, zx;
    op = ins[31:26]; fn = ins[5:0];
    sx = {{16{ins[15]}}, ins[15:0]};
    zx = {16'h0, ins[15:0]};
    b = '0; b.valid = 1'b1; b.pc = pc; b.rs = rsv; b.rt = rtv; b.shamt = ins[10:6];
    if (op == 6'h00) begin
      if (r_tab.exists(fn)) begin
        b.alu = r_tab[fn]; b.rwr = 1'b1; b.dest = ins[15:11];
      end else b.ill = 1'b1;
    end else if (op == 6'h02) begin
      b.br = 2'b11; b.imm = {pc[31:28], ins[25:0], 2'b00};
    end else if (i_tab.exists(op)) begin
      b.alu = i_tab[op];
      case (op)
        6'h04:               begin b.br = 2'b01; b.imm = sx; end
        6'h05:               begin b.br = 2'b10; b.imm = sx; end
        6'h23:               begin b.src = 1; b.mrd = 1; b.rwr = 1; b.dest = ins[20:16]; b.imm = sx; end
        6'h2B:               begin b.src = 1; b.mwr = 1; b.imm = sx; end
        6'h0C, 6'h0D, 6'h0E: begin b.src = 1; b.rwr = 1; b.dest = ins[20:16]; b.imm = zx; end
        6'h0F:               begin b.src = 1; b.rwr = 1; b.dest = ins[20:16]; b.imm = {ins[15:0], 16'h0}; end
        default:             begin b.src = 1; b.rwr = 1; b.dest = ins[20:16]; b.imm = sx; end
      endcase
    end else b.ill = 1'b1;
    return b;
  endfunction

  // One clock: drive at negedge, check stall_out, advance model at posedge, check bundle
  task automatic cycle(input logic rst, input logic v, input logic [31:0] ins,
                       input logic [31:0] pc, input logic st, input logic we,
                       input logic [4:0] wa, input logic [31:0] wd);
    bun_t nxt;
    logic hz, est;
    logic [4:0] rs, rt;
    @(negedge clk_in);
    rst_n_in = rst; valid_in = v; insn_in = ins; pc_in = pc; stall_in = st;
    wb_en_in = we; wb_addr_in = wa; wb_data_in = wd;
    #1;
    rs = ins[25:21]; rt = ins[20:16];
    hz  = mb.valid && mb.mrd && (mb.dest != 0) && (mb.dest == rs || (reads_rt(ins) && mb.dest == rt));
    est = st | (rst & hz);
    last_stall = stall_out;
    chk("stall_out", CW'(stall_out), CW'(est));
    if (!rst)          nxt = '0;
    else if (st)       nxt = mb;
    else if (hz || !v) nxt = '0;
    else nxt = ref_decode(ins, pc, rd_reg(rs, we, wa, wd), rd_reg(rt, we, wa, wd));
    @(posedge clk_in);
    if (!rst) for (int i = 0; i < 32; i++) mregs[i] = '0;
    else if (we && wa != 0) mregs[wa] = wd;
    mb = nxt;
    #1;
    chk("bundle", CW'(got), CW'(mb));
  endtask

  task automatic issue(input logic [31:0] ins, input logic [31:0] pc);
    cycle(1'b1, 1'b1, ins, pc, 1'b0, 1'b0, 5'd0, 32'd0);
  endtask

  function automatic logic [31:0] rand_insn();
    logic [5:0]  ops [13];
    logic [5:0]  fns [13];
    logic [31:0] r, ins;
    ops = '{6'h00, 6'h02, 6'h04, 6'h05, 6'h08, 6'h09, 6'h0A, 6'h0C, 6'h0D, 6'h0E, 6'h0F, 6'h23, 6'h2B};
    fns = '{6'h00, 6'h02, 6'h03, 6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h26, 6'h27, 6'h2A, 6'h2B};
    r = $urandom();
    if ($urandom_range(0, 15) == 0) return r;
    ins = {ops[$urandom_range(0, 12)], r[25:0]};
    if (ins[31:26] == 6'h00 && $urandom_range(0, 7) != 0) ins[5:0] = fns[$urandom_range(0, 12)];
    if ($urandom_range(0, 1) == 1) begin
      ins[25:21] = 5'($urandom_range(0, 3));
      ins[20:16] = 5'($urandom_range(0, 3));
    end
    return ins;
  endfunction

  initial begin
    logic [31:0] ins, pcv, wd;
    logic        rst, v, st, we;
    logic [4:0]  wa;
    mb = '0;
    last_stall = 1'b0;
    for (int i = 0; i < 32; i++) mregs[i] = '0;
    r_tab[6'h20] = 0; r_tab[6'h21] = 0; r_tab[6'h22] = 1; r_tab[6'h23] = 1;
    r_tab[6'h24] = 2; r_tab[6'h25] = 3; r_tab[6'h26] = 4; r_tab[6'h27] = 5;
    r_tab[6'h2A] = 6; r_tab[6'h2B] = 7; r_tab[6'h00] = 8; r_tab[6'h02] = 9; r_tab[6'h03] = 10;
    i_tab[6'h08] = 0; i_tab[6'h09] = 0; i_tab[6'h0A] = 6; i_tab[6'h0C] = 2; i_tab[6'h0D] = 3;
    i_tab[6'h0E] = 4; i_tab[6'h0F] = 11; i_tab[6'h23] = 0; i_tab[6'h2B] = 0;
    i_tab[6'h04] = 1; i_tab[6'h05] = 1;

    //            insn          pc            alu src imm           dest rwr mrd mwr br    ill
    tab[0]  = '{32'h2001FFFF, 32'h00000100, 0,  1, 32'hFFFFFFFF, 1,  1,  0,  0,  2'b00, 0};
    tab[1]  = '{32'h34028000, 32'h00000104, 3,  1, 32'h00008000, 2,  1,  0,  0,  2'b00, 0};
    tab[2]  = '{32'h3C038000, 32'h00000108, 11, 1, 32'h80000000, 3,  1,  0,  0,  2'b00, 0};
    tab[3]  = '{32'hFC000000, 32'h0000010C, 0,  0, 32'h00000000, 0,  0,  0,  0,  2'b00, 1};
    tab[4]  = '{32'h00432020, 32'h00000110, 0,  0, 32'h00000000, 4,  1,  0,  0,  2'b00, 0};
    tab[5]  = '{32'h00222822, 32'h00000114, 1,  0, 32'h00000000, 5,  1,  0,  0,  2'b00, 0};
    tab[6]  = '{32'h000130C3, 32'h00000118, 10, 0, 32'h00000000, 6,  1,  0,  0,  2'b00, 0};
    tab[7]  = '{32'h2827FFFB, 32'h0000011C, 6,  1, 32'hFFFFFFFB, 7,  1,  0,  0,  2'b00, 0};
    tab[8]  = '{32'h3028F0F0, 32'h00000120, 2,  1, 32'h0000F0F0, 8,  1,  0,  0,  2'b00, 0};
    tab[9]  = '{32'hAC240008, 32'h00000124, 0,  1, 32'h00000008, 0,  0,  0,  1,  2'b00, 0};
    tab[10] = '{32'h1022FFFE, 32'h00000128, 1,  0, 32'hFFFFFFFE, 0,  0,  0,  0,  2'b01, 0};
    tab[11] = '{32'h14200004, 32'h0000012C, 1,  0, 32'h00000004, 0,  0,  0,  0,  2'b10, 0};
    tab[12] = '{32'h08ABCDEF, 32'hA0000040, 0,  0, 32'hA2AF37BC, 0,  0,  0,  0,  2'b11, 0};
    tab[13] = '{32'h8C290004, 32'h00000134, 0,  1, 32'h00000004, 9,  1,  1,  0,  2'b00, 0};
    tab[14] = '{32'h00000000, 32'h00000138, 8,  0, 32'h00000000, 0,  1,  0,  0,  2'b00, 0};
    tab[15] = '{32'h00000001, 32'h0000013C, 0,  0, 32'h00000000, 0,  0,  0,  0,  2'b00, 1};
    tab[16] = '{32'h3821FFFF, 32'h00000140, 4,  1, 32'h0000FFFF, 1,  1,  0,  0,  2'b00, 0};
    tab[17] = '{32'h00225027, 32'h00000144, 5,  0, 32'h00000000, 10, 1,  0,  0,  2'b00, 0};

    // Reset, then explicit all-zero output check
    cycle(1'b0, 1'b1, 32'h2001FFFF, 32'h10, 1'b0, 1'b1, 5'd3, 32'h55);
    cycle(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 5'd0, 32'h0);
    chk("reset_zero", CW'(got), CW'(0));

    // Directed decode table
    for (int i = 0; i < 18; i++) begin
      issue(tab[i].insn, tab[i].pc);
      chk($sformatf("tab[%0d]", i),
          CW'({got.valid, got.alu, got.src, got.imm, got.dest, got.rwr, got.mrd, got.mwr, got.br, got.ill}),
          CW'({1'b1, tab[i].alu, tab[i].src, tab[i].imm, tab[i].dest, tab[i].rwr, tab[i].mrd,
               tab[i].mwr, tab[i].br, tab[i].ill}));
      if (i == 0) chk("addi_rs_data", CW'(rs_data_out), CW'(0));
    end

    // Writeback bypass, then regfile read, then $0 write ignored
    cycle(1'b1, 1'b1, 32'h00A51820, 32'h200, 1'b0, 1'b1, 5'd5, 32'h1234);
    chk("bypass_rs", CW'(rs_data_out), CW'(32'h1234));
    chk("bypass_rt", CW'(rt_data_out), CW'(32'h1234));
    issue(32'h00A51820, 32'h204);
    chk("rf_read_rs", CW'(rs_data_out), CW'(32'h1234));
    cycle(1'b1, 1'b1, 32'h00001820, 32'h208, 1'b0, 1'b1, 5'd0, 32'hDEAD);
    chk("r0_bypass", CW'({rs_data_out, rt_data_out}), CW'(0));
    issue(32'h00001820, 32'h20C);
    chk("r0_read", CW'({rs_data_out, rt_data_out}), CW'(0));

    // Load-use: stall one cycle, bubble, then the ADD decodes
    issue(32'h8C220000, 32'h300);
    issue(32'h00432020, 32'h304);
    chk("ldu_stall", CW'(last_stall), CW'(1));
    chk("ldu_bubble", CW'(valid_out), CW'(0));
    issue(32'h00432020, 32'h304);
    chk("ldu_release", CW'(last_stall), CW'(0));
    chk("ldu_add", CW'({valid_out, pc_out, dest_out, alu_op_out}), CW'({1'b1, 32'h304, 5'd4, 4'd0}));

    // Downstream stall for three cycles: outputs frozen, no loss or duplication
    issue(32'h2001FFFF, 32'h400);
    for (int i = 0; i < 3; i++) begin
      cycle(1'b1, 1'b1, 32'h34028000, 32'h404, 1'b1, 1'b0, 5'd0, 32'h0);
      chk("stall_hold_pc", CW'({valid_out, pc_out}), CW'({1'b1, 32'h400}));
      chk("stall_out_hi", CW'(last_stall), CW'(1));
    end
    issue(32'h34028000, 32'h404);
    chk("stall_resume", CW'({pc_out, imm_out}), CW'({32'h404, 32'h00008000}));
    issue(32'h3C038000, 32'h408);
    chk("stall_next", CW'(pc_out), CW'(32'h408));

    // Mid-stream reset with a pending load-use hazard and a writeback
    cycle(1'b1, 1'b1, 32'h8C220000, 32'h500, 1'b0, 1'b1, 5'd7, 32'hCAFE);
    cycle(1'b0, 1'b1, 32'h00432020, 32'h504, 1'b0, 1'b1, 5'd8, 32'hBEEF);
    chk("rst_stall_low", CW'(last_stall), CW'(0));
    chk("rst_outputs", CW'(got), CW'(0));
    issue(32'h00E81820, 32'h508);
    chk("rst_rf_clear", CW'({rs_data_out, rt_data_out}), CW'(0));

    // Randomized traffic against the reference model
    for (int n = 0; n < 1500; n++) begin
      ins = rand_insn();
      pcv = $urandom();
      rst = ($urandom_range(0, 99) != 0);
      v   = ($urandom_range(0, 9) != 0);
      st  = ($urandom_range(0, 6) == 0);
      we  = ($urandom_range(0, 1) == 1);
      wa  = 5'($urandom_range(0, 31));
      wd  = $urandom();
      cycle(rst, v, ins, pcv, st, we, wa, wd);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
    $fatal(1, "watchdog");
  end

endmodule
